// File: rtl/multicycle_sequencer.sv
// Multi-cycle sequencing FSM for the RV32I core.
// Walks each instruction through FETCH/DECODE/EXEC/MEM/WB, turns the decoder's
// raw control bits into single-cycle enables, and waits on variable-latency
// instruction/data memories with a watchdog that parks the core in FAULT.
module multicycle_sequencer #(
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst,
   output logic             imem_req,
   input  logic             imem_ready,
   output logic             ir_we,
   input  logic             dec_RegWr,
   input  logic             dec_MemWr,
   input  logic             dec_MemtoReg,
   input  logic             dec_Branch,
   input  logic             dec_jump,
   input  logic             br_taken,
   output logic             dmem_req,
   output logic             dmem_we,
   input  logic             dmem_ready,
   output logic             reg_we,
   output logic             pc_we,
   output logic             pc_sel,
   output logic [CNT_W-1:0] instret,
   output logic             fault,
   output logic [2:0]       state
);

   // Wait counter is wide enough to hold TIMEOUT; with the watchdog disabled
   // it stays a single bit pinned at zero.
   localparam int              WC_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [WC_W-1:0] WC_MAX = WC_W'(TIMEOUT);

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_FAULT  = 3'd7
   } state_t;

   state_t            state_r, state_s;
   logic [WC_W-1:0]   wait_cnt_r, wait_cnt_s;
   logic [CNT_W-1:0]  instret_r, instret_s;
   logic              fault_r, fault_s;
   logic              timeout_s;

   // Saturating increment: the counter never wraps past TIMEOUT.
   function automatic logic [WC_W-1:0] sat_inc(input logic [WC_W-1:0] v);
      logic [WC_W-1:0] r;
      if (v == WC_MAX) begin
         r = v;
      end else begin
         r = v + WC_W'(1);
      end
      return r;
   endfunction

   // Watchdog expiry: counter reached the limit and the watchdog is enabled.
   always_comb begin
      timeout_s = 1'b0;
      if (TIMEOUT != 0) begin
         timeout_s = (wait_cnt_r == WC_MAX);
      end else begin
         timeout_s = 1'b0;
      end
   end

   // Next-state, wait counter, retire counter and sticky fault.
   always_comb begin
      state_s    = state_r;
      wait_cnt_s = wait_cnt_r;
      instret_s  = instret_r;
      fault_s    = fault_r;
      case (state_r)
         ST_FETCH: begin
            if (imem_ready) begin
               state_s = ST_DECODE;
            end else if (timeout_s) begin
               state_s = ST_FAULT;
               fault_s = 1'b1;
            end else begin
               wait_cnt_s = sat_inc(wait_cnt_r);
            end
         end
         ST_DECODE: begin
            state_s = ST_EXEC;
         end
         ST_EXEC: begin
            if (dec_MemWr || dec_MemtoReg) begin
               state_s    = ST_MEM;
               wait_cnt_s = '0;
            end else begin
               state_s = ST_WB;
            end
         end
         ST_MEM: begin
            // ready in the timeout cycle still completes normally
            if (dmem_ready) begin
               state_s = ST_WB;
            end else if (timeout_s) begin
               state_s = ST_FAULT;
               fault_s = 1'b1;
            end else begin
               wait_cnt_s = sat_inc(wait_cnt_r);
            end
         end
         ST_WB: begin
            instret_s  = instret_r + CNT_W'(1);
            state_s    = ST_FETCH;
            wait_cnt_s = '0;
         end
         ST_FAULT: begin
            state_s = ST_FAULT;
            fault_s = 1'b1;
         end
         default: begin
            state_s    = ST_FETCH;
            wait_cnt_s = '0;
         end
      endcase
   end

   // Strobe decode of the registered state; everything is held low in reset.
   always_comb begin
      imem_req = 1'b0;
      ir_we    = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      reg_we   = 1'b0;
      pc_we    = 1'b0;
      pc_sel   = 1'b0;
      if (rst) begin
         imem_req = 1'b0;
      end else begin
         case (state_r)
            ST_FETCH: begin
               imem_req = 1'b1;
               ir_we    = imem_ready;
            end
            ST_MEM: begin
               dmem_req = 1'b1;
               dmem_we  = dec_MemWr;
            end
            ST_WB: begin
               reg_we = dec_RegWr;
               pc_we  = 1'b1;
               pc_sel = dec_jump | (dec_Branch & br_taken);
            end
            default: begin
               imem_req = 1'b0;
            end
         endcase
      end
   end

   // State and counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_FETCH;
         wait_cnt_r <= '0;
         instret_r  <= '0;
         fault_r    <= 1'b0;
      end else begin
         state_r    <= state_s;
         wait_cnt_r <= wait_cnt_s;
         instret_r  <= instret_s;
         fault_r    <= fault_s;
      end
   end

   assign instret = instret_r;
   assign fault   = fault_r;
   assign state   = state_r;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer: a per-cycle vector table,
// hand-written multi-cycle corner sequences and a randomized run against a
// behavioural model of the instruction flow.
module tb_multicycle_sequencer;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_ready = 1'b0, dmem_ready = 1'b0;
   logic        dec_RegWr = 1'b0, dec_MemWr = 1'b0, dec_MemtoReg = 1'b0;
   logic        dec_Branch = 1'b0, dec_jump = 1'b0, br_taken = 1'b0;
   logic        imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we, pc_sel, fault;
   logic [31:0] instret;
   logic [2:0]  state;
   logic [6:0]  strb;

   int n_pass  = 0;
   int n_total = 0;

   multicycle_sequencer #(.TIMEOUT(TO), .CNT_W(32)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_ready(imem_ready), .ir_we(ir_we),
      .dec_RegWr(dec_RegWr), .dec_MemWr(dec_MemWr), .dec_MemtoReg(dec_MemtoReg),
      .dec_Branch(dec_Branch), .dec_jump(dec_jump), .br_taken(br_taken),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
      .reg_we(reg_we), .pc_we(pc_we), .pc_sel(pc_sel),
      .instret(instret), .fault(fault), .state(state)
   );

   assign strb = {imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we, pc_sel};

   always #5 clk = ~clk;

   // Input vector order: {rst, imem_ready, dmem_ready, RegWr, MemWr, MemtoReg, Branch, jump, br_taken}
   localparam logic [8:0] I_RST  = 9'b1_1_1_1_1_1_1_1_1;
   localparam logic [8:0] I_ADDI = 9'b0_1_0_1_0_0_0_0_0;
   localparam logic [8:0] I_SW   = 9'b0_1_1_0_1_0_0_0_0;
   localparam logic [8:0] I_BEQT = 9'b0_1_0_0_0_0_1_0_1;
   localparam logic [8:0] I_BEQN = 9'b0_1_0_0_0_0_1_0_0;
   localparam logic [8:0] I_JAL  = 9'b0_1_0_1_0_0_1_1_0;
   localparam logic [8:0] I_IDLE = 9'b0_0_0_0_0_0_0_0_0;
   localparam logic [8:0] I_LW   = 9'b0_0_0_1_0_1_0_0_0;
   // Strobe order: {imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we, pc_sel}
   localparam logic [6:0] S_0  = 7'b0000000;
   localparam logic [6:0] S_F  = 7'b1100000;
   localparam logic [6:0] S_FW = 7'b1000000;

   typedef struct {
      logic [8:0]  in;
      logic [2:0]  st;
      logic [6:0]  sb;
      logic [31:0] ic;
   } vec_t;

   vec_t tbl[$];
   int   lw_st [11] = '{0, 0, 0, 0, 1, 2, 3, 3, 3, 4, 0};

   // behavioural model: phase code, consecutive stall count, retired count, fault
   int          m_ph;
   int          m_stall;
   logic [31:0] m_ic;
   logic        m_flt;
   logic [6:0]  m_sb;
   int          prob;
   int          n_req;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic set_in(input logic [8:0] v);
      {rst, imem_ready, dmem_ready, dec_RegWr, dec_MemWr, dec_MemtoReg,
       dec_Branch, dec_jump, br_taken} = v;
   endtask

   task automatic add(input logic [8:0] in, input logic [2:0] st, input logic [6:0] sb,
                      input int ic);
      vec_t v;
      v.in = in; v.st = st; v.sb = sb; v.ic = 32'(ic);
      tbl.push_back(v);
   endtask

   task automatic do_reset();
      @(negedge clk);
      set_in(I_RST);
      #1;
   endtask

   task automatic run_addi();
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         set_in(I_ADDI);
         #1;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      // ---------------- table of per-cycle vectors ----------------
      add(I_RST,  3'd0, S_0, 0);
      add(I_ADDI, 3'd0, S_F, 0); add(I_ADDI, 3'd1, S_0, 0);
      add(I_ADDI, 3'd2, S_0, 0); add(I_ADDI, 3'd4, 7'b0000110, 0);
      add(I_SW,   3'd0, S_F, 1); add(I_SW,   3'd1, S_0, 1); add(I_SW, 3'd2, S_0, 1);
      add(I_SW,   3'd3, 7'b0011000, 1); add(I_SW, 3'd4, 7'b0000010, 1);
      add(I_BEQT, 3'd0, S_F, 2); add(I_BEQT, 3'd1, S_0, 2);
      add(I_BEQT, 3'd2, S_0, 2); add(I_BEQT, 3'd4, 7'b0000011, 2);
      add(I_BEQN, 3'd0, S_F, 3); add(I_BEQN, 3'd1, S_0, 3);
      add(I_BEQN, 3'd2, S_0, 3); add(I_BEQN, 3'd4, 7'b0000010, 3);
      add(I_JAL,  3'd0, S_F, 4); add(I_JAL,  3'd1, S_0, 4);
      add(I_JAL,  3'd2, S_0, 4); add(I_JAL,  3'd4, 7'b0000111, 4);
      add(I_IDLE, 3'd0, S_FW, 5);

      set_in(I_RST);
      @(posedge clk);
      foreach (tbl[i]) begin
         @(negedge clk);
         set_in(tbl[i].in);
         #1;
         chk($sformatf("tbl[%0d] state", i), 32'(state), 32'(tbl[i].st));
         chk($sformatf("tbl[%0d] strobes", i), 32'(strb), 32'(tbl[i].sb));
         chk($sformatf("tbl[%0d] instret", i), instret, tbl[i].ic);
         chk($sformatf("tbl[%0d] fault", i), 32'(fault), 32'd0);
      end

      // ---------------- lw: imem 3 waits, dmem 2 waits, 10 cycles ----------------
      do_reset();
      for (int c = 0; c < 11; c++) begin
         @(negedge clk);
         set_in(I_LW);
         imem_ready = (c == 3);
         dmem_ready = (c == 8);
         #1;
         chk($sformatf("lw c%0d state", c), 32'(state), 32'(lw_st[c]));
         if (c >= 6 && c <= 8) begin
            chk("lw dmem_req", 32'(dmem_req), 32'd1);
            chk("lw dmem_we", 32'(dmem_we), 32'd0);
         end
         if (c == 9) chk("lw reg_we", 32'(reg_we), 32'd1);
      end
      chk("lw instret", instret, 32'd1);

      // ---------------- fetch timeout -> FAULT, frozen, reset ----------------
      do_reset();
      run_addi();
      n_req = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         set_in(I_IDLE);
         #1;
         if (imem_req) n_req++;
      end
      chk("timeout imem_req cycles", 32'(n_req), 32'd17);
      chk("timeout state", 32'(state), 32'd7);
      chk("timeout fault", 32'(fault), 32'd1);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         set_in(9'b0_1_1_1_1_1_1_1_1);
         #1;
         chk("fault strobes", 32'(strb), 32'd0);
         chk("fault state held", 32'(state), 32'd7);
         chk("fault instret frozen", instret, 32'd1);
      end
      @(negedge clk);
      set_in(I_RST);
      #1;
      chk("fault rst strobes", 32'(strb), 32'd0);
      @(negedge clk);
      set_in(I_IDLE);
      #1;
      chk("post-rst state", 32'(state), 32'd0);
      chk("post-rst fault", 32'(fault), 32'd0);
      chk("post-rst instret", instret, 32'd0);
      chk("post-rst strobes", 32'(strb), 32'(S_FW));

      // ---------------- ready exactly at wait_cnt==TIMEOUT ----------------
      do_reset();
      for (int c = 0; c < 18; c++) begin
         @(negedge clk);
         set_in(I_IDLE);
         imem_ready = (c == TO);
         #1;
         chk($sformatf("edge c%0d state", c), 32'(state), (c <= TO) ? 32'd0 : 32'd1);
         if (c == TO) chk("edge ir_we", 32'(ir_we), 32'd1);
      end
      chk("edge fault", 32'(fault), 32'd0);

      // ---------------- reset in second MEM wait cycle of a store ----------------
      do_reset();
      run_addi();
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         set_in(I_SW);
         dmem_ready = 1'b0;
         rst = (c == 4);
         #1;
         if (c == 3) begin
            chk("abort dmem_req", 32'(dmem_req), 32'd1);
            chk("abort instret before", instret, 32'd1);
         end
      end
      chk("abort dmem_req in rst", 32'(dmem_req), 32'd0);
      chk("abort dmem_we in rst", 32'(dmem_we), 32'd0);
      chk("abort imem_req in rst", 32'(imem_req), 32'd0);
      @(negedge clk);
      set_in(I_IDLE);
      #1;
      chk("abort state", 32'(state), 32'd0);
      chk("abort instret", instret, 32'd0);

      // ---------------- randomized run against the model ----------------
      do_reset();
      m_ph = 0; m_stall = 0; m_ic = '0; m_flt = 1'b0; prob = 50;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         if (cyc % 100 == 0) begin
            case ($urandom_range(0, 3))
               0: prob = 5;
               1: prob = 30;
               2: prob = 70;
               default: prob = 100;
            endcase
         end
         rst          = m_flt ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 399) == 0);
         imem_ready   = ($urandom_range(0, 99) < prob);
         dmem_ready   = ($urandom_range(0, 99) < prob);
         dec_RegWr    = 1'($urandom_range(0, 1));
         dec_MemWr    = 1'($urandom_range(0, 1));
         dec_MemtoReg = 1'($urandom_range(0, 1));
         dec_Branch   = 1'($urandom_range(0, 1));
         dec_jump     = 1'($urandom_range(0, 1));
         br_taken     = 1'($urandom_range(0, 1));
         #1;
         // expected strobes for the current phase
         m_sb = S_0;
         if (!rst) begin
            if (m_ph == 0) m_sb = {1'b1, imem_ready, 5'b00000};
            if (m_ph == 3) m_sb = {2'b00, 1'b1, dec_MemWr, 3'b000};
            if (m_ph == 4) m_sb = {4'b0000, dec_RegWr, 1'b1, dec_jump | (dec_Branch & br_taken)};
         end
         chk("rnd state", 32'(state), 32'(m_ph));
         chk("rnd strobes", 32'(strb), 32'(m_sb));
         chk("rnd instret", instret, m_ic);
         chk("rnd fault", 32'(fault), 32'(m_flt));
         // advance the model: a wait faults after TO+1 consecutive unready cycles
         if (rst) begin
            m_ph = 0; m_stall = 0; m_ic = '0; m_flt = 1'b0;
         end else if (m_ph == 0 || m_ph == 3) begin
            if ((m_ph == 0) ? imem_ready : dmem_ready) begin
               m_ph    = (m_ph == 0) ? 1 : 4;
               m_stall = 0;
            end else if (m_stall == TO) begin
               m_ph  = 7;
               m_flt = 1'b1;
            end else begin
               m_stall++;
            end
         end else if (m_ph == 1) begin
            m_ph = 2;
         end else if (m_ph == 2) begin
            m_ph = (dec_MemWr || dec_MemtoReg) ? 3 : 4;
         end else if (m_ph == 4) begin
            m_ic = m_ic + 32'd1;
            m_ph = 0;
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle sequencing FSM for the RV32I core; sits beside the instruction decoder.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB over one shared clock.
- Gates the decoder's raw strobes (RegWr, MemWr, MemtoReg, Branch, jump) into single-cycle enables for the register file, PC and data memory.
- Handshakes with variable-latency instruction and data memories, with a watchdog on each wait.

Parameters:
- TIMEOUT, 64, maximum memory wait cycles before FAULT; 0 disables the watchdog.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  instruction fetch request.
- imem_ready  in  1  fetch data valid this cycle.
- ir_we  out  1  load instruction register.
- dec_RegWr  in  1  decoder RegWr for the current IR.
- dec_MemWr  in  1  decoder MemWr.
- dec_MemtoReg  in  1  decoder MemtoReg; marks a load.
- dec_Branch  in  1  decoder Branch; also 1 for jal/jalr.
- dec_jump  in  1  decoder jump.
- br_taken  in  1  branch comparison result from ALU.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data memory write enable.
- dmem_ready  in  1  data access complete.
- reg_we  out  1  register file write enable.
- pc_we  out  1  PC update enable.
- pc_sel  out  1  1 = target PC, 0 = PC+4.
- instret  out  CNT_W  retired-instruction count.
- fault  out  1  sticky memory-timeout flag.
- state  out  3  FSM state, for debug.

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, FAULT=7. Codes 5 and 6 go to FETCH.
- Reset:
  - state=FETCH, instret=0, fault=0, wait_cnt=0.
  - While rst=1, every strobe output is forced to 0. This includes imem_req, dmem_req, dmem_we, ir_we, reg_we, pc_we and pc_sel.
  - Reset mid-operation abandons the access; dmem_req/imem_req drop in the same cycle rst is asserted.
- Strobes are Moore/Mealy combinational decodes of the registered state; there are no registered strobe outputs.
- FETCH:
  - imem_req=1, held until imem_ready.
  - On imem_ready: ir_we=1 in the same cycle, then go to DECODE.
- DECODE: one cycle for decoder and register-file read to settle; then go to EXEC.
- EXEC: one cycle. If dec_MemWr|dec_MemtoReg, go to MEM; else go to WB.
- MEM:
  - dmem_req=1 and dmem_we=dec_MemWr, both held until dmem_ready.
  - On dmem_ready, go to WB.
- WB: one cycle.
  - reg_we=dec_RegWr.
  - pc_we=1.
  - pc_sel=dec_jump | (dec_Branch & br_taken).
  - instret+=1, wrapping modulo 2^CNT_W.
  - Then go to FETCH.
- Latency (ready seen in the first wait cycle): non-memory instruction 4 cycles; load/store 5 cycles. Each extra wait cycle adds 1.
- Watchdog:
  - wait_cnt clears on entry to FETCH and MEM, and increments every cycle in those states while ready=0.
  - If wait_cnt==TIMEOUT and ready=0, go to FAULT.
  - ready asserted in the same cycle as the timeout condition wins: normal transition, no fault.
  - wait_cnt saturates at TIMEOUT.
- FAULT:
  - fault=1, all strobes 0, state held until rst.
  - instret is frozen.
- Stores: reg_we=0 in WB because dec_RegWr=0. reg_we is never asserted outside WB.
- dmem_req and imem_req are never high simultaneously.

Test Plan:
- addi, imem_ready=1 on the first FETCH cycle:
  - state sequence 0,1,2,4,0.
  - ir_we pulses once; reg_we=1 and pc_we=1 in WB only; pc_sel=0.
  - instret 0→1 after 4 cycles.
- lw, imem_ready after 3 wait cycles, dmem_ready after 2 wait cycles:
  - dmem_we=0 in MEM.
  - reg_we=1 in WB.
  - Total 10 cycles; instret=1.
- sw, both readies immediate:
  - dmem_req=1, dmem_we=1 for exactly 1 cycle.
  - reg_we stays 0 throughout; total 5 cycles.
- beq, dec_Branch=1:
  - br_taken=1 gives pc_sel=1 in WB.
  - Repeated with br_taken=0 gives pc_sel=0.
  - jal (dec_jump=1, br_taken=0) gives pc_sel=1 and reg_we=1.
- TIMEOUT=16, imem_ready held 0:
  - imem_req high 17 cycles, then state=7 and fault=1; all strobes 0 afterwards.
  - rst pulse returns state=0, fault=0, instret=0.
  - Edge case: imem_ready=1 exactly at wait_cnt==16 gives DECODE, no fault.
- rst asserted in the second MEM wait cycle of a store:
  - dmem_req/dmem_we go to 0 in the same cycle.
  - The next cycle has state=0, and instret is unchanged by the aborted instruction (reset to 0).
